// File: rtl/usb_system_pio_pkg.sv
// Shared register map for the usb_system software/fabric PIO slaves.
// Used by the from_sw_sig output PIO and the to_sw_sig input PIO read mux.
package usb_system_pio_pkg;

  typedef logic [2:0] pio_addr_t;

  localparam pio_addr_t ADDR_DATA   = 3'd0;
  localparam pio_addr_t ADDR_PULSE  = 3'd2;
  localparam pio_addr_t ADDR_OUTSET = 3'd4;
  localparam pio_addr_t ADDR_OUTCLR = 3'd5;

endpackage

// File: rtl/usb_system_pio_pulse_gen.sv
// One-shot pulse register: loaded bits stay high for PULSE_LEN cycles.
// A load during an active pulse ORs in new bits and restarts the count.
module usb_system_pio_pulse_gen #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] bits,
  output logic [WIDTH-1:0] pulse_reg
);

  localparam int unsigned CW = $clog2(PULSE_LEN + 1);

  logic [CW-1:0] counter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_reg <= '0;
      counter   <= '0;
    end else if (load) begin
      pulse_reg <= pulse_reg | bits;
      counter   <= CW'(PULSE_LEN - 1);
    end else if (pulse_reg != '0) begin
      // Counter holds remaining cycles minus one; zero means this is the last high cycle.
      if (counter == '0) begin
        pulse_reg <= '0;
      end else begin
        counter <= counter - 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_system_from_sw_sig.sv
// Avalon-MM output PIO: software drives WIDTH control bits into fabric logic.
// Optional timed one-shot pulses at address 2 when FROM_SW_SIG_PULSE_EN is defined.
module usb_system_from_sw_sig
  import usb_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      PULSE_LEN   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             out_strobe
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] out_port_d1;
  logic             unused_writedata;

  assign wr               = chipselect && !write_n;
  assign wd               = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_reg <= wd;
        ADDR_OUTSET: data_reg <= data_reg | wd;
        ADDR_OUTCLR: data_reg <= data_reg & ~wd;
        default:     data_reg <= data_reg;
      endcase
    end
  end

`ifdef FROM_SW_SIG_PULSE_EN
  logic [WIDTH-1:0] pulse_reg;
  logic             pulse_load;

  assign pulse_load = wr && (address == ADDR_PULSE) && (wd != '0);

  usb_system_pio_pulse_gen #(
    .WIDTH     (WIDTH),
    .PULSE_LEN (PULSE_LEN)
  ) u_pulse_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (pulse_load),
    .bits      (wd),
    .pulse_reg (pulse_reg)
  );

  assign out_port = data_reg | pulse_reg;
`else
  assign out_port = data_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA:  readdata <= 32'(data_reg);
`ifdef FROM_SW_SIG_PULSE_EN
        ADDR_PULSE: readdata <= 32'(pulse_reg);
`endif
        default:    readdata <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port_d1 <= RESET_VALUE;
    end else begin
      out_port_d1 <= out_port;
    end
  end

  // Both sides reset to RESET_VALUE, so no strobe appears on the first cycle after reset.
  assign out_strobe = (out_port != out_port_d1);

endmodule

// File: tb/tb_usb_system_from_sw_sig.sv
// Directed self-checking bench for usb_system_from_sw_sig (WIDTH=2, PULSE_LEN=4).
// Pulse scenarios are exercised when FROM_SW_SIG_PULSE_EN is defined.
module tb_usb_system_from_sw_sig;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  out_port;
  logic        out_strobe;

  int errors = 0;
  int checks = 0;

  usb_system_from_sw_sig #(
    .WIDTH       (2),
    .RESET_VALUE (2'b00),
    .PULSE_LEN   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_strobe (out_strobe)
  );

  always #5 clk = ~clk;

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    idle();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (out_port !== 2'b00) begin
        errors++;
        $display("FAIL reset_out_port cycle %0d: got %b expected 00", i, out_port);
      end
      checks++;
      if (out_strobe !== 1'b0) begin
        errors++;
        $display("FAIL reset_strobe cycle %0d: got %b expected 0", i, out_strobe);
      end
      checks++;
      if (readdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_readdata cycle %0d: got %h expected 00000000", i, readdata);
      end
    end
  endtask

  task automatic test_direct_write();
    bus_write(3'd0, 32'h3);
    checks++;
    if (out_port !== 2'b11) begin
      errors++;
      $display("FAIL data_write_out: got %b expected 11", out_port);
    end
    checks++;
    if (out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL data_write_strobe: got %b expected 1", out_strobe);
    end
    idle();
    checks++;
    if (out_strobe !== 1'b0) begin
      errors++;
      $display("FAIL strobe_one_cycle: got %b expected 0", out_strobe);
    end
    bus_write(3'd0, 32'h3);
    checks++;
    if (out_strobe !== 1'b0 || out_port !== 2'b11) begin
      errors++;
      $display("FAIL rewrite_no_strobe: got strobe=%b out=%b expected 0/11", out_strobe, out_port);
    end
    address = 3'd0;
    idle();
    checks++;
    if (readdata !== 32'h3) begin
      errors++;
      $display("FAIL read_data: got %h expected 00000003", readdata);
    end
  endtask

  task automatic test_set_clr();
    bus_write(3'd5, 32'h1);
    checks++;
    if (out_port !== 2'b10 || out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL outclr: got out=%b strobe=%b expected 10/1", out_port, out_strobe);
    end
    bus_write(3'd4, 32'h1);
    checks++;
    if (out_port !== 2'b11 || out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL outset: got out=%b strobe=%b expected 11/1", out_port, out_strobe);
    end
    bus_write(3'd0, 32'h0);
    checks++;
    if (out_port !== 2'b00 || out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL data_clear: got out=%b strobe=%b expected 00/1", out_port, out_strobe);
    end
    idle();
  endtask

`ifdef FROM_SW_SIG_PULSE_EN
  task automatic test_pulse_single();
    bus_write(3'd2, 32'h1);
    checks++;
    if (out_port !== 2'b01 || out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL pulse_rise: got out=%b strobe=%b expected 01/1", out_port, out_strobe);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (out_port !== 2'b01 || out_strobe !== 1'b0) begin
        errors++;
        $display("FAIL pulse_hold cycle %0d: got out=%b strobe=%b expected 01/0", i, out_port, out_strobe);
      end
      if (i == 0) begin
        checks++;
        if (readdata !== 32'h1) begin
          errors++;
          $display("FAIL pulse_read_active: got %h expected 00000001", readdata);
        end
      end
    end
    idle();
    checks++;
    if (out_port !== 2'b00 || out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL pulse_fall: got out=%b strobe=%b expected 00/1", out_port, out_strobe);
    end
    idle();
    checks++;
    if (readdata !== 32'h0 || out_strobe !== 1'b0) begin
      errors++;
      $display("FAIL pulse_read_after: got rd=%h strobe=%b expected 00000000/0", readdata, out_strobe);
    end
    bus_write(3'd2, 32'h0);
    checks++;
    if (out_port !== 2'b00 || out_strobe !== 1'b0) begin
      errors++;
      $display("FAIL pulse_zero_write: got out=%b strobe=%b expected 00/0", out_port, out_strobe);
    end
  endtask

  task automatic test_pulse_extend();
    bus_write(3'd2, 32'h1);
    idle();
    checks++;
    if (out_port !== 2'b01) begin
      errors++;
      $display("FAIL extend_first: got %b expected 01", out_port);
    end
    bus_write(3'd2, 32'h2);
    checks++;
    if (out_port !== 2'b11 || out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL extend_second: got out=%b strobe=%b expected 11/1", out_port, out_strobe);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (out_port !== 2'b11) begin
        errors++;
        $display("FAIL extend_hold cycle %0d: got %b expected 11", i, out_port);
      end
    end
    idle();
    checks++;
    if (out_port !== 2'b00 || out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL extend_fall: got out=%b strobe=%b expected 00/1", out_port, out_strobe);
    end
    idle();
  endtask
`else
  task automatic test_pulse_disabled();
    bus_write(3'd2, 32'h3);
    checks++;
    if (out_port !== 2'b00 || out_strobe !== 1'b0) begin
      errors++;
      $display("FAIL addr2_ignored: got out=%b strobe=%b expected 00/0", out_port, out_strobe);
    end
    address = 3'd2;
    idle();
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL addr2_read: got %h expected 00000000", readdata);
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [1:0] exp_before;
    bus_write(3'd0, 32'h1);
    exp_before = 2'b01;
`ifdef FROM_SW_SIG_PULSE_EN
    bus_write(3'd2, 32'h2);
    exp_before = 2'b11;
`endif
    address = 3'd0;
    idle();
    checks++;
    if (out_port !== exp_before) begin
      errors++;
      $display("FAIL pre_reset_out: got %b expected %b", out_port, exp_before);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_port !== 2'b00 || out_strobe !== 1'b0 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got out=%b strobe=%b rd=%h expected 00/0/00000000",
               out_port, out_strobe, readdata);
    end
    idle();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle();
      checks++;
      if (out_port !== 2'b00 || out_strobe !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cycle %0d: got out=%b strobe=%b expected 00/0", i, out_port, out_strobe);
      end
    end
  endtask

  task automatic test_ignored_writes();
    logic [2:0] ign [4] = '{3'd1, 3'd3, 3'd6, 3'd7};
    bus_write(3'd0, 32'h2);
    idle();
    address    = 3'd0;
    writedata  = 32'hFFFF_FFFF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    idle();
    write_n = 1'b1;
    checks++;
    if (out_port !== 2'b10 || out_strobe !== 1'b0) begin
      errors++;
      $display("FAIL no_chipselect: got out=%b strobe=%b expected 10/0", out_port, out_strobe);
    end
    foreach (ign[k]) begin
      bus_write(ign[k], 32'hFFFF_FFFF);
      checks++;
      if (out_port !== 2'b10 || out_strobe !== 1'b0) begin
        errors++;
        $display("FAIL ignored_addr %0d: got out=%b strobe=%b expected 10/0", ign[k], out_port, out_strobe);
      end
      checks++;
      if (readdata !== 32'h0) begin
        errors++;
        $display("FAIL ignored_read %0d: got %h expected 00000000", ign[k], readdata);
      end
    end
    address = 3'd0;
    idle();
    checks++;
    if (readdata !== 32'h2) begin
      errors++;
      $display("FAIL read_after_ignored: got %h expected 00000002", readdata);
    end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_set_clr();
`ifdef FROM_SW_SIG_PULSE_EN
    test_pulse_single();
    test_pulse_extend();
`else
    test_pulse_disabled();
`endif
    test_async_reset();
    test_ignored_writes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
